if_stage: RTL and testbench

//  Instruction-fetch stage of the LEGv8 pipeline: owns the PC register, drives pc_o

---
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage.sv | 103 ++++++++++
 tb/tb_if_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls and inst_mem data in, fetch address and IF/ID contents out.
interface if_stage_if #(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32,
    parameter int CNT_W     = 32
);
    logic                 stall;
    logic                 redirect_valid;
    logic [WORD-1:0]      redirect_pc;
    logic                 halt_req;
    logic [INST_SIZE-1:0] inst_i;
    logic [WORD-1:0]      pc_o;
    logic                 ifid_valid;
    logic [WORD-1:0]      ifid_pc;
    logic [INST_SIZE-1:0] ifid_inst;
    logic                 halted;
    logic [CNT_W-1:0]     fetch_cnt;

    // Driving side: hazard logic, redirect source and inst_mem.
    modport master (
        output stall, redirect_valid, redirect_pc, halt_req, inst_i,
        input  pc_o, ifid_valid, ifid_pc, ifid_inst, halted, fetch_cnt
    );

    // The fetch stage itself.
    modport slave (
        input  stall, redirect_valid, redirect_pc, halt_req, inst_i,
        output pc_o, ifid_valid, ifid_pc, ifid_inst, halted, fetch_cnt
    );
endinterface

// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage: PC register, IF/ID pipeline register,
// one-cycle boot bubble, sticky halt and a saturating fetch counter.
module if_stage #(
    parameter int              WORD      = 64,
    parameter int              INST_SIZE = 32,
    parameter int              CNT_W     = 32,
    parameter logic [WORD-1:0] RESET_PC  = '0
) (
    input  logic      clk,
    input  logic      rst,
    if_stage_if.slave bus
);
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t               r_state,     w_state_nxt;
    logic [WORD-1:0]      r_pc,        w_pc_nxt;
    logic                 r_ifid_valid, w_ifid_valid_nxt;
    logic [WORD-1:0]      r_ifid_pc,   w_ifid_pc_nxt;
    logic [INST_SIZE-1:0] r_ifid_inst, w_ifid_inst_nxt;
    logic                 r_halted,    w_halted_nxt;
    logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;
    logic [WORD-1:0]      w_redirect_aligned;

    // Redirect targets are forced onto a word boundary.
    assign w_redirect_aligned = bus.redirect_pc & ~WORD'(3);

    // Next-state and next-register values; everything holds unless a branch below changes it.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_valid_nxt = r_ifid_valid;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_inst_nxt  = r_ifid_inst;
        w_halted_nxt     = r_halted;
        w_cnt_nxt        = r_cnt;
        case (r_state)
            S_BOOT: begin
                w_state_nxt      = S_RUN;
                w_ifid_valid_nxt = 1'b0;
                if (bus.redirect_valid) begin
                    w_pc_nxt = w_redirect_aligned;
                end
            end
            S_RUN: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt         = w_redirect_aligned;
                    w_ifid_valid_nxt = 1'b0;
                    w_ifid_inst_nxt  = '0;
                end else if (bus.halt_req) begin
                    w_state_nxt      = S_HALT;
                    w_halted_nxt     = 1'b1;
                    w_ifid_valid_nxt = 1'b0;
                end else if (!bus.stall) begin
                    w_ifid_pc_nxt    = r_pc;
                    w_ifid_inst_nxt  = bus.inst_i;
                    w_ifid_valid_nxt = 1'b1;
                    w_pc_nxt         = r_pc + WORD'(4);
                    if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_HALT: begin
                w_ifid_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset overriding all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_inst  <= '0;
            r_halted     <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_inst  <= w_ifid_inst_nxt;
            r_halted     <= w_halted_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    assign bus.pc_o       = r_pc;
    assign bus.ifid_valid = r_ifid_valid;
    assign bus.ifid_pc    = r_ifid_pc;
    assign bus.ifid_inst  = r_ifid_inst;
    assign bus.halted     = r_halted;
    assign bus.fetch_cnt  = r_cnt;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a vector table on a default instance and a hand-written
// saturation/reset sequence on a CNT_W=3 instance, checked through a scoreboard queue.
module tb_if_stage;
    logic clk;
    logic rst0;
    logic rst1;

    if_stage_if #(.WORD(64), .INST_SIZE(32), .CNT_W(32)) bus0 ();
    if_stage_if #(.WORD(64), .INST_SIZE(32), .CNT_W(3))  bus1 ();

    if_stage #(.WORD(64), .INST_SIZE(32), .CNT_W(32), .RESET_PC(64'd0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0.slave)
    );

    if_stage #(.WORD(64), .INST_SIZE(32), .CNT_W(3), .RESET_PC(64'd0)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave)
    );

    // Instruction memory: word at byte address A holds A/4.
    assign bus0.inst_i = bus0.pc_o[33:2];
    assign bus1.inst_i = bus1.pc_o[33:2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [63:0] rpc;
        logic        halt;
        logic [63:0] pc;
        logic        v;
        logic [63:0] ipc;
        logic [31:0] inst;
        logic        h;
        logic [63:0] cnt;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [NVEC];
    vec_t sb [$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic rst, input logic stall, input logic rv,
                                input logic [63:0] rpc, input logic halt,
                                input logic [63:0] pc, input logic v, input logic [63:0] ipc,
                                input logic [31:0] inst, input logic h, input logic [63:0] cnt);
        vec_t r;
        r.rst = rst; r.stall = stall; r.rv = rv; r.rpc = rpc; r.halt = halt;
        r.pc = pc; r.v = v; r.ipc = ipc; r.inst = inst; r.h = h; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector on the chosen DUT, queue its expectation, compare after the edge.
    task automatic apply(input int which, input int idx, input vec_t v);
        vec_t e;
        logic [63:0] a_pc, a_ipc, a_cnt;
        logic [31:0] a_inst;
        logic        a_v, a_h;
        @(negedge clk);
        if (which == 0) begin
            rst0 = v.rst; bus0.stall = v.stall; bus0.redirect_valid = v.rv;
            bus0.redirect_pc = v.rpc; bus0.halt_req = v.halt;
        end else begin
            rst1 = v.rst; bus1.stall = v.stall; bus1.redirect_valid = v.rv;
            bus1.redirect_pc = v.rpc; bus1.halt_req = v.halt;
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard vec %0d: got empty queue expected entry", idx);
        end else begin
            e = sb.pop_front();
            if (which == 0) begin
                a_pc = bus0.pc_o; a_v = bus0.ifid_valid; a_ipc = bus0.ifid_pc;
                a_inst = bus0.ifid_inst; a_h = bus0.halted; a_cnt = 64'(bus0.fetch_cnt);
            end else begin
                a_pc = bus1.pc_o; a_v = bus1.ifid_valid; a_ipc = bus1.ifid_pc;
                a_inst = bus1.ifid_inst; a_h = bus1.halted; a_cnt = 64'(bus1.fetch_cnt);
            end
            n_vec++;
            chk("pc_o",       idx, a_pc,         e.pc);
            chk("ifid_valid", idx, 64'(a_v),     64'(e.v));
            chk("ifid_pc",    idx, a_ipc,        e.ipc);
            chk("ifid_inst",  idx, 64'(a_inst),  64'(e.inst));
            chk("halted",     idx, 64'(a_h),     64'(e.h));
            chk("fetch_cnt",  idx, a_cnt,        e.cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned k;
        logic [63:0] ecnt;
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.stall = 1'b0; bus0.redirect_valid = 1'b0; bus0.redirect_pc = '0; bus0.halt_req = 1'b0;
        bus1.stall = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0; bus1.halt_req = 1'b0;

        //              rst stl rv rpc                      hlt  pc                       v  ipc                      inst           h  cnt
        tbl[0]  = mk(1, 0, 0, 64'h0,                 0, 64'h0,                 0, 64'h0,                 32'd0,         0, 64'd0);
        tbl[1]  = mk(0, 0, 0, 64'h0,                 0, 64'h0,                 0, 64'h0,                 32'd0,         0, 64'd0);
        tbl[2]  = mk(0, 0, 0, 64'h0,                 0, 64'h4,                 1, 64'h0,                 32'd0,         0, 64'd1);
        tbl[3]  = mk(0, 0, 0, 64'h0,                 0, 64'h8,                 1, 64'h4,                 32'd1,         0, 64'd2);
        tbl[4]  = mk(0, 0, 0, 64'h0,                 0, 64'hC,                 1, 64'h8,                 32'd2,         0, 64'd3);
        tbl[5]  = mk(0, 1, 0, 64'h0,                 0, 64'hC,                 1, 64'h8,                 32'd2,         0, 64'd3);
        tbl[6]  = mk(0, 1, 0, 64'h0,                 0, 64'hC,                 1, 64'h8,                 32'd2,         0, 64'd3);
        tbl[7]  = mk(0, 1, 0, 64'h0,                 0, 64'hC,                 1, 64'h8,                 32'd2,         0, 64'd3);
        tbl[8]  = mk(0, 0, 0, 64'h0,                 0, 64'h10,                1, 64'hC,                 32'd3,         0, 64'd4);
        tbl[9]  = mk(0, 0, 0, 64'h0,                 0, 64'h14,                1, 64'h10,                32'd4,         0, 64'd5);
        tbl[10] = mk(0, 1, 1, 64'h43,                0, 64'h40,                0, 64'h10,                32'd0,         0, 64'd5);
        tbl[11] = mk(0, 0, 0, 64'h0,                 0, 64'h44,                1, 64'h40,                32'd16,        0, 64'd6);
        tbl[12] = mk(0, 0, 0, 64'h0,                 1, 64'h44,                0, 64'h40,                32'd16,        1, 64'd6);
        tbl[13] = mk(0, 0, 1, 64'h100,               0, 64'h44,                0, 64'h40,                32'd16,        1, 64'd6);
        tbl[14] = mk(0, 1, 0, 64'h0,                 0, 64'h44,                0, 64'h40,                32'd16,        1, 64'd6);
        tbl[15] = mk(1, 0, 0, 64'h0,                 0, 64'h0,                 0, 64'h0,                 32'd0,         0, 64'd0);
        tbl[16] = mk(0, 0, 1, 64'hFFFFFFFFFFFFFFFC,  0, 64'hFFFFFFFFFFFFFFFC,  0, 64'h0,                 32'd0,         0, 64'd0);
        tbl[17] = mk(0, 0, 0, 64'h0,                 0, 64'h0,                 1, 64'hFFFFFFFFFFFFFFFC,  32'hFFFFFFFF,  0, 64'd1);
        tbl[18] = mk(0, 0, 0, 64'h0,                 0, 64'h4,                 1, 64'h0,                 32'd0,         0, 64'd2);
        tbl[19] = mk(1, 0, 0, 64'h0,                 0, 64'h0,                 0, 64'h0,                 32'd0,         0, 64'd0);
        tbl[20] = mk(0, 1, 0, 64'h0,                 1, 64'h0,                 0, 64'h0,                 32'd0,         0, 64'd0);
        tbl[21] = mk(0, 0, 0, 64'h0,                 0, 64'h4,                 1, 64'h0,                 32'd0,         0, 64'd1);
        tbl[22] = mk(1, 1, 1, 64'h80,                1, 64'h0,                 0, 64'h0,                 32'd0,         0, 64'd0);

        for (int i = 0; i < NVEC; i++) begin
            apply(0, i, tbl[i]);
        end

        // Narrow counter: reset, boot bubble, ten advances saturating at 7, then reset mid-stall.
        apply(1, 100, mk(1, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 32'd0, 0, 64'd0));
        apply(1, 101, mk(0, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 32'd0, 0, 64'd0));
        for (k = 1; k <= 10; k++) begin
            ecnt = (k > 7) ? 64'd7 : 64'(k);
            apply(1, 101 + int'(k), mk(0, 0, 0, 64'h0, 0, 64'(4 * k), 1, 64'(4 * (k - 1)),
                                      32'(k - 1), 0, ecnt));
        end
        apply(1, 112, mk(0, 1, 0, 64'h0, 0, 64'd40, 1, 64'd36, 32'd9, 0, 64'd7));
        apply(1, 113, mk(1, 1, 0, 64'h0, 0, 64'h0,  0, 64'h0,  32'd0, 0, 64'd0));

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
